// File: rtl/result_bcd_converter.sv
// Signed 8-bit to sign + 3-digit BCD converter using an 8-step sequential double-dabble.
// Optional 7-segment decode outputs are enabled by defining SEG7_OUT_EN.
module result_bcd_converter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] sum_in,
  output logic       busy,
  output logic       done,
  output logic       neg,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
`ifdef SEG7_OUT_EN
  ,
  output logic [6:0] seg_hund,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic [6:0] seg_sign
`endif
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  mag_q, mag_d;
  logic [11:0] scr_q, scr_d;
  logic        sign_q, sign_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        neg_q, neg_d;
  logic [11:0] bcd_q, bcd_d;

  logic [11:0] scr_adj;
  logic [11:0] scr_next;
  logic [7:0]  mag_next;

  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // One double-dabble step: correct each digit, then shift {digits, magnitude} left.
  always_comb begin
    scr_adj  = {dabble_adj(scr_q[11:8]), dabble_adj(scr_q[7:4]), dabble_adj(scr_q[3:0])};
    scr_next = {scr_adj[10:0], mag_q[7]};
    mag_next = {mag_q[6:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d  = sum_in[7];
          // 0x80 negates to 0x80, which read unsigned is the required 128.
          mag_d   = sum_in[7] ? (~sum_in + 8'd1) : sum_in;
          scr_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        scr_d = scr_next;
        mag_d = mag_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          bcd_d   = scr_next;
          neg_d   = sign_q & (|scr_next);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mag_q   <= '0;
      scr_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign neg      = neg_q;
  assign bcd_hund = bcd_q[11:8];
  assign bcd_tens = bcd_q[7:4];
  assign bcd_ones = bcd_q[3:0];

`ifdef SEG7_OUT_EN
  // Segment order gfedcba, active-high.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b0000000;
    case (d)
      4'd0: s = 7'b0111111;
      4'd1: s = 7'b0000110;
      4'd2: s = 7'b1011011;
      4'd3: s = 7'b1001111;
      4'd4: s = 7'b1100110;
      4'd5: s = 7'b1101101;
      4'd6: s = 7'b1111101;
      4'd7: s = 7'b0000111;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Gated by rst so the display stays dark while reset is held.
  always_comb begin
    seg_hund = 7'b0000000;
    seg_tens = 7'b0000000;
    seg_ones = 7'b0000000;
    seg_sign = 7'b0000000;
    if (rst) begin
      seg_hund = (bcd_q[11:8] == 4'd0) ? 7'b0000000 : seg_decode(bcd_q[11:8]);
      seg_tens = seg_decode(bcd_q[7:4]);
      seg_ones = seg_decode(bcd_q[3:0]);
      seg_sign = neg_q ? 7'b1000000 : 7'b0000000;
    end
  end
`endif

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed self-checking bench for result_bcd_converter; segment checks compile only with
// SEG7_OUT_EN defined.
module tb_result_bcd_converter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] sum_in;
  logic       busy;
  logic       done;
  logic       neg;
  logic [3:0] bcd_hund;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
`ifdef SEG7_OUT_EN
  logic [6:0] seg_hund;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic [6:0] seg_sign;
`endif

  int n_cmp;
  int n_bad;

  result_bcd_converter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sum_in   (sum_in),
    .busy     (busy),
    .done     (done),
    .neg      (neg),
    .bcd_hund (bcd_hund),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones)
`ifdef SEG7_OUT_EN
    ,
    .seg_hund (seg_hund),
    .seg_tens (seg_tens),
    .seg_ones (seg_ones),
    .seg_sign (seg_sign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: one-cycle start, then count edges until done (bounded at 20).
  task automatic run_conv(input logic [7:0] v, output int lat, output int busy_cnt);
    @(negedge clk);
    start  = 1'b1;
    sum_in = v;
    @(negedge clk);
    start  = 1'b0;
    sum_in = ~v;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    start  = 1'b0;
    sum_in = 8'h00;
    #1;
    n_cmp++;
    if ({busy, done, neg, bcd_hund, bcd_tens, bcd_ones} !== 15'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, done, neg, bcd_hund, bcd_tens, bcd_ones});
    end
`ifdef SEG7_OUT_EN
    n_cmp++;
    if ({seg_hund, seg_tens, seg_ones, seg_sign} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_seg: got %h expected 0", {seg_hund, seg_tens, seg_ones, seg_sign});
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int bc;
    run_conv(8'h07, lat, bc);
    n_cmp++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d expected 8", lat);
    end
    n_cmp++;
    if (bc !== 8) begin
      n_bad++;
      $display("FAIL basic_busy_cycles: got %0d expected 8", bc);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy_at_done: got %b expected 0", busy);
    end
    n_cmp++;
    if ({neg, bcd_hund, bcd_tens, bcd_ones} !== 13'h0007) begin
      n_bad++;
      $display("FAIL basic_result: got %h expected 0007", {neg, bcd_hund, bcd_tens, bcd_ones});
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_width: got %b expected 0", done);
    end
  endtask

  task automatic test_signed();
    logic [7:0]  vin [6];
    logic [12:0] vexp [6];
    int lat;
    int bc;
    vin[0] = 8'hF0; vexp[0] = 13'h1016;
    vin[1] = 8'h80; vexp[1] = 13'h1128;
    vin[2] = 8'h7F; vexp[2] = 13'h0127;
    vin[3] = 8'h00; vexp[3] = 13'h0000;
    vin[4] = 8'hFF; vexp[4] = 13'h1001;
    vin[5] = 8'h64; vexp[5] = 13'h0100;
    for (int i = 0; i < 6; i++) begin
      run_conv(vin[i], lat, bc);
      n_cmp++;
      if (lat !== 8 || {neg, bcd_hund, bcd_tens, bcd_ones} !== vexp[i]) begin
        n_bad++;
        $display("FAIL signed_%h: got lat %0d val %h expected lat 8 val %h",
                 vin[i], lat, {neg, bcd_hund, bcd_tens, bcd_ones}, vexp[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    int first_c;
    logic [12:0] got;
    ndone   = 0;
    first_c = -1;
    got     = '0;
    @(negedge clk);
    start  = 1'b1;
    sum_in = 8'h05;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_c < 0) begin
          first_c = c;
          got     = {neg, bcd_hund, bcd_tens, bcd_ones};
        end
      end
      start  = (c == 2);
      sum_in = (c == 2) ? 8'h09 : 8'h00;
    end
    n_cmp++;
    if (ndone !== 1 || first_c !== 8) begin
      n_bad++;
      $display("FAIL ignore_done_count: got %0d at %0d expected 1 at 8", ndone, first_c);
    end
    n_cmp++;
    if (got !== 13'h0005) begin
      n_bad++;
      $display("FAIL ignore_result: got %h expected 0005", got);
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int at [3];
    logic [12:0] exp_v;
    ndone = 0;
    for (int k = 0; k < 3; k++) at[k] = -1;
    @(negedge clk);
    start  = 1'b1;
    sum_in = 8'h0E;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (done) begin
        exp_v = (ndone % 2 == 0) ? 13'h0014 : 13'h1015;
        n_cmp++;
        if ({neg, bcd_hund, bcd_tens, bcd_ones} !== exp_v) begin
          n_bad++;
          $display("FAIL b2b_result_%0d: got %h expected %h",
                   ndone, {neg, bcd_hund, bcd_tens, bcd_ones}, exp_v);
        end
        if (ndone < 3) at[ndone] = c;
        ndone++;
        sum_in = (ndone % 2 == 1) ? 8'hF1 : 8'h0E;
        if (ndone == 3) start = 1'b0;
      end
    end
    // Each result: 8 busy cycles plus the done cycle that resamples start.
    n_cmp++;
    if (ndone !== 3 || at[0] !== 8 || at[1] !== 17 || at[2] !== 26) begin
      n_bad++;
      $display("FAIL b2b_timing: got %0d dones at %0d/%0d/%0d expected 3 at 8/17/26",
               ndone, at[0], at[1], at[2]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int bc;
    int ndone;
    run_conv(8'hF0, lat, bc);
    @(negedge clk);
    start  = 1'b1;
    sum_in = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, neg, bcd_hund, bcd_tens, bcd_ones} !== 15'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h expected 0",
               {busy, done, neg, bcd_hund, bcd_tens, bcd_ones});
    end
    @(negedge clk);
    rst   = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_bad++;
      $display("FAIL midreset_no_done: got %0d expected 0", ndone);
    end
    run_conv(8'h0C, lat, bc);
    n_cmp++;
    if (lat !== 8 || {neg, bcd_hund, bcd_tens, bcd_ones} !== 13'h0012) begin
      n_bad++;
      $display("FAIL midreset_recover: got lat %0d val %h expected lat 8 val 0012",
               lat, {neg, bcd_hund, bcd_tens, bcd_ones});
    end
  endtask

`ifdef SEG7_OUT_EN
  task automatic test_seg();
    int lat;
    int bc;
    run_conv(8'hF9, lat, bc);
    n_cmp++;
    if ({seg_hund, seg_tens, seg_ones, seg_sign} !==
        {7'b0000000, 7'b0111111, 7'b0000111, 7'b1000000}) begin
      n_bad++;
      $display("FAIL seg_neg7: got %b %b %b %b expected 0000000 0111111 0000111 1000000",
               seg_hund, seg_tens, seg_ones, seg_sign);
    end
    run_conv(8'h80, lat, bc);
    n_cmp++;
    if ({seg_hund, seg_tens, seg_ones, seg_sign} !==
        {7'b0000110, 7'b1011011, 7'b1111111, 7'b1000000}) begin
      n_bad++;
      $display("FAIL seg_neg128: got %b %b %b %b expected 0000110 1011011 1111111 1000000",
               seg_hund, seg_tens, seg_ones, seg_sign);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SEG7_OUT_EN
    test_seg();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
